// File: rtl/apb_master_mc_if.sv
// Request/response port and shared APB4 bus of the multi-slave APB master.
// The master modport is the bridge's view; the slave modport is the core adapter plus peripherals.
interface apb_master_mc_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [DATA_WIDTH-1:0]            req_wdata;
  logic [STRB_W-1:0]                req_strb;
  logic                             rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_rdata;
  logic                             rsp_err;
  logic [ADDR_WIDTH-1:0]            paddr;
  logic [NUM_SLAVES-1:0]            psel;
  logic                             penable;
  logic                             pwrite;
  logic [DATA_WIDTH-1:0]            pwdata;
  logic [STRB_W-1:0]                pstrb;
  logic [NUM_SLAVES-1:0]            pready;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;
  logic [NUM_SLAVES-1:0]            pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  pready, prdata, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output pready, prdata, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_mc.sv
// APB4 master: valid/ready requests decoded onto NUM_SLAVES one-hot selects,
// with wait states, strobes, slave/decode errors and an ACCESS-phase timeout.
module apb_master_mc #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_ADDR_BITS = 8,
  parameter int unsigned TIMEOUT         = 16
) (
  input logic            clk,
  input logic            rst,
  apb_master_mc_if.master bus
);
  localparam int unsigned IDX_W = ADDR_WIDTH - SLAVE_ADDR_BITS;
  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic [SEL_W-1:0]      sel_q;
  logic [CNT_W-1:0]      wait_cnt;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_hit;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timed_out;

  assign req_idx   = bus.req_addr[ADDR_WIDTH-1:SLAVE_ADDR_BITS];
  assign req_hit   = 32'(req_idx) < NUM_SLAVES;
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Decode of the incoming request and view of the currently selected slave only.
  always_comb begin
    req_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      req_onehot[i] = (req_idx == IDX_W'(i));
      if (sel_q == SEL_W'(i)) begin
        sel_ready = bus.pready[i];
        sel_err   = bus.pslverr[i];
        sel_rdata = bus.prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel_q         <= '0;
      wait_cnt      <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.paddr     <= '0;
      bus.psel      <= '0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.pwdata    <= '0;
      bus.pstrb     <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (req_hit) begin
              state         <= SETUP;
              sel_q         <= SEL_W'(req_idx);
              bus.req_ready <= 1'b0;
              bus.psel      <= req_onehot;
              bus.paddr     <= bus.req_addr;
              bus.pwrite    <= bus.req_write;
              bus.pstrb     <= bus.req_write ? bus.req_strb : '0;
              if (bus.req_write) bus.pwdata <= bus.req_wdata;
            end else begin
              // Unmapped slave index: answer immediately without touching the bus.
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
          wait_cnt    <= '0;
        end
        ACCESS: begin
          if (sel_ready || timed_out) begin
            state         <= IDLE;
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= sel_ready ? sel_err : 1'b1;
            if (sel_ready && !sel_err && !bus.pwrite) bus.rsp_rdata <= sel_rdata;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_mc.sv
// Directed bench for apb_master_mc: write, wait-state read, decode error,
// slave error, timeout, back-to-back acceptance and mid-transfer reset.
module tb_apb_master_mc;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  apb_master_mc_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_SLAVES(4)) bus ();

  apb_master_mc #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_SLAVES(4), .SLAVE_ADDR_BITS(8), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.pready    = '0;
    bus.pslverr   = '0;
    bus.prdata    = {32'hC0C0_3333, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_0000};

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'h1);
    chk("rst_psel", 64'(bus.psel), 64'h0);
    chk("rst_penable", 64'(bus.penable), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_paddr", 64'(bus.paddr), 64'h0);
    rst = 1'b0;
    tick();

    // Zero-wait write to slave 3
    request(1'b1, 12'h300, 32'd13, 4'hF);
    bus.pready = 4'b1000;
    tick();
    bus.req_valid = 1'b0;
    chk("wr_setup_psel", 64'(bus.psel), 64'h8);
    chk("wr_setup_penable", 64'(bus.penable), 64'h0);
    chk("wr_setup_ready", 64'(bus.req_ready), 64'h0);
    chk("wr_paddr", 64'(bus.paddr), 64'h300);
    chk("wr_pwrite", 64'(bus.pwrite), 64'h1);
    chk("wr_pwdata", 64'(bus.pwdata), 64'd13);
    chk("wr_pstrb", 64'(bus.pstrb), 64'hF);
    tick();
    chk("wr_access_penable", 64'(bus.penable), 64'h1);
    chk("wr_access_rsp", 64'(bus.rsp_valid), 64'h0);
    tick();
    chk("wr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("wr_rsp_err", 64'(bus.rsp_err), 64'h0);
    chk("wr_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("wr_done_psel", 64'(bus.psel), 64'h0);
    chk("wr_done_penable", 64'(bus.penable), 64'h0);
    chk("wr_done_ready", 64'(bus.req_ready), 64'h1);
    bus.pready = 4'b0000;
    tick();
    chk("wr_rsp_pulse", 64'(bus.rsp_valid), 64'h0);

    // Read from slave 1 with three wait states
    request(1'b0, 12'h104, 32'hFFFF_FFFF, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    chk("rd_setup_psel", 64'(bus.psel), 64'h2);
    chk("rd_pstrb", 64'(bus.pstrb), 64'h0);
    chk("rd_pwrite", 64'(bus.pwrite), 64'h0);
    chk("rd_pwdata_held", 64'(bus.pwdata), 64'd13);
    tick();
    chk("rd_a1_penable", 64'(bus.penable), 64'h1);
    tick();
    chk("rd_a2_paddr", 64'(bus.paddr), 64'h104);
    chk("rd_a2_psel", 64'(bus.psel), 64'h2);
    tick();
    chk("rd_a3_penable", 64'(bus.penable), 64'h1);
    chk("rd_a3_rsp", 64'(bus.rsp_valid), 64'h0);
    tick();
    bus.pready = 4'b0010;
    chk("rd_a4_penable", 64'(bus.penable), 64'h1);
    chk("rd_a4_rsp", 64'(bus.rsp_valid), 64'h0);
    tick();
    bus.pready = 4'b0000;
    chk("rd_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("rd_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    chk("rd_rsp_err", 64'(bus.rsp_err), 64'h0);
    chk("rd_done_penable", 64'(bus.penable), 64'h0);
    tick();

    // Decode error: slave index 5
    request(1'b0, 12'h500, 32'h0, 4'h0);
    bus.pready = 4'b1111;
    tick();
    bus.req_valid = 1'b0;
    chk("dec_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("dec_rsp_err", 64'(bus.rsp_err), 64'h1);
    chk("dec_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("dec_psel", 64'(bus.psel), 64'h0);
    chk("dec_ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("dec_idle_psel", 64'(bus.psel), 64'h0);
    chk("dec_rsp_pulse", 64'(bus.rsp_valid), 64'h0);
    bus.pready = 4'b0000;

    // Slave error on read from slave 2
    request(1'b0, 12'h2F0, 32'h0, 4'h0);
    bus.pready  = 4'b0100;
    bus.pslverr = 4'b0100;
    tick();
    bus.req_valid = 1'b0;
    chk("serr_psel", 64'(bus.psel), 64'h4);
    tick();
    tick();
    chk("serr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("serr_rsp_err", 64'(bus.rsp_err), 64'h1);
    chk("serr_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    bus.pready  = 4'b0000;
    bus.pslverr = 4'b0000;
    tick();

    // Timeout on slave 0 while the other slaves report ready
    request(1'b0, 12'h000, 32'h0, 4'h0);
    bus.pready = 4'b1110;
    tick();
    bus.req_valid = 1'b0;
    chk("to_psel", 64'(bus.psel), 64'h1);
    for (int i = 0; i < 15; i++) tick();
    chk("to_a15_rsp", 64'(bus.rsp_valid), 64'h0);
    tick();
    chk("to_a16_penable", 64'(bus.penable), 64'h1);
    chk("to_a16_rsp", 64'(bus.rsp_valid), 64'h0);
    tick();
    chk("to_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("to_rsp_err", 64'(bus.rsp_err), 64'h1);
    chk("to_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("to_psel_off", 64'(bus.psel), 64'h0);
    chk("to_penable_off", 64'(bus.penable), 64'h0);
    bus.pready = 4'b0000;
    tick();

    // Back-to-back: second request held valid, accepted in first's response cycle
    bus.pready = 4'b0011;
    request(1'b1, 12'h0A0, 32'h0000_00AA, 4'h3);
    tick();
    chk("b2b1_psel", 64'(bus.psel), 64'h1);
    chk("b2b1_pstrb", 64'(bus.pstrb), 64'h3);
    request(1'b0, 12'h110, 32'h0, 4'hF);
    tick();
    chk("b2b1_penable", 64'(bus.penable), 64'h1);
    tick();
    chk("b2b1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("b2b1_rsp_err", 64'(bus.rsp_err), 64'h0);
    chk("b2b1_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b2_psel", 64'(bus.psel), 64'h2);
    chk("b2b2_paddr", 64'(bus.paddr), 64'h110);
    chk("b2b2_pwdata_held", 64'(bus.pwdata), 64'hAA);
    tick();
    tick();
    chk("b2b2_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("b2b2_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    bus.pready = 4'b0000;
    tick();

    // Reset during ACCESS of a third transfer
    request(1'b0, 12'h204, 32'h0, 4'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rst_mid_penable_pre", 64'(bus.penable), 64'h1);
    rst = 1'b1;
    tick();
    chk("rst_mid_psel", 64'(bus.psel), 64'h0);
    chk("rst_mid_penable", 64'(bus.penable), 64'h0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'h1);
    chk("rst_mid_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("rst_mid_paddr", 64'(bus.paddr), 64'h0);
    chk("rst_mid_pwdata", 64'(bus.pwdata), 64'h0);
    rst = 1'b0;
    bus.pready = 4'b1111;
    tick();
    chk("rst_after_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("rst_after_psel", 64'(bus.psel), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/apb_master_mc.md
Name: apb_master_mc

Overview:
- Parametrised APB4 master that bridges a valid/ready request port onto a shared APB bus with NUM_SLAVES one-hot select lines.
- Sits between the core-side bus adapter and the peripheral slaves.
- Adds over the single-slave master: internal address decode to a per-slave PSEL, wait-state support, PSTRB, PSLVERR return, decode-error response and a wait-state timeout.

Parameters:
ADDR_WIDTH, 12, width of request and APB address.
DATA_WIDTH, 32, width of write/read data; must be a multiple of 8.
NUM_SLAVES, 4, number of APB slaves (1..16).
SLAVE_ADDR_BITS, 8, low address bits inside one slave window; slave index = addr[ADDR_WIDTH-1:SLAVE_ADDR_BITS].
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  write data.
req_strb  in  DATA_WIDTH/8  write byte strobes.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  DATA_WIDTH  read data (0 on writes and errors).
rsp_err  out  1  slave error, decode error or timeout.
paddr  out  ADDR_WIDTH  APB address.
psel  out  NUM_SLAVES  one-hot slave select.
penable  out  1  APB access phase.
pwrite  out  1  APB direction.
pwdata  out  DATA_WIDTH  APB write data.
pstrb  out  DATA_WIDTH/8  APB strobes.
pready  in  NUM_SLAVES  per-slave ready.
prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
pslverr  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset: rst sampled high at a clk edge puts the block in IDLE.
  - All outputs are 0 after reset except req_ready, which is 1.
  - Reset mid-transfer aborts it with no rsp_valid and drops psel/penable on the next edge.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - req_ready = 1.
  - On handshake, latch addr, write, wdata and strb, and compute idx.
  - If idx < NUM_SLAVES: go to SETUP.
  - Otherwise (decode error): stay in IDLE, drive no psel, and pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle.
- SETUP (1 cycle):
  - psel[idx]=1, penable=0; paddr/pwrite/pwdata valid.
  - pstrb = latched strb on writes, 0 on reads.
  - req_ready = 0. Next state ACCESS.
- ACCESS:
  - penable=1; all APB outputs held stable.
  - Completion when pready[idx]=1: next cycle is IDLE with psel=0, penable=0 and rsp_valid=1.
    - rsp_err = pslverr[idx].
    - rsp_rdata = prdata slice idx on reads without error, else 0.
- Timeout: a wait counter increments on each ACCESS cycle with pready[idx]=0.
  - When it reaches TIMEOUT (TIMEOUT > 0), abort: next cycle IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The counter clears on entering ACCESS.
- Only pready/pslverr/prdata of the selected slave are observed; other slaves' signals are ignored.
- rsp_valid is high for exactly one cycle per accepted request; there is no response backpressure.
- Back-to-back: req_ready is 1 in the rsp_valid cycle, so a new request may be accepted then.
  - Zero-wait transfer: handshake cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 (new accept possible at N+3).
- pwdata retains its last value on reads (don't care); paddr holds between transfers.

Test Plan:
- Write, zero wait: addr 0x300, wdata 13, strb 0xF, pready[3]=1.
  - psel=4'b1000 at N+1, penable at N+2, pstrb=0xF.
  - rsp_valid at N+3 with err=0, rdata=0.
- Read with 3 wait states: addr 0x104, slave 1 prdata=0xDEADBEEF, pready[1] high on the 4th ACCESS cycle.
  - penable stays high for 4 cycles with stable paddr/psel=4'b0010 and pstrb=0.
  - rsp_rdata=0xDEADBEEF, err=0.
- Decode error: addr 0x500 (idx 5 ≥ 4).
  - psel stays 0; rsp_valid next cycle with err=1, rdata=0.
- Slave error and timeout:
  - Read of 0x2F0 with pslverr[2]=1 and pready[2]=1 gives err=1, rdata=0.
  - Read of 0x000 with pready[0] held low and TIMEOUT=16 aborts after 16 ACCESS cycles with err=1, then psel=0.
- Back-to-back plus reset: two requests with req_valid held; the second is accepted in the first's rsp_valid cycle.
  - rst pulsed during ACCESS of a third transfer gives all outputs 0, req_ready=1 and no rsp_valid.
